// File: rtl/booth_seq_multiplier_pkg.sv
// ---------------------------------------------------------------------------
// booth_seq_multiplier_pkg
// Shared definitions for the sequential radix-2 Booth multiplier:
//   - DEFAULT_WIDTH : default operand width
//   - state_t       : control FSM encoding (2'd3 is unused and recovers to IDLE)
//   - booth_op_t    : Booth recoding operation for one step
//   - booth_decode  : maps the {Q[0], Q(-1)} pair to a Booth operation
// ---------------------------------------------------------------------------
package booth_seq_multiplier_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'd0,
        BOOTH_ADD = 2'd1,
        BOOTH_SUB = 2'd2
    } booth_op_t;

    // 01 -> end of a run of ones: add M; 10 -> start of a run: subtract M.
    function automatic booth_op_t booth_decode(input logic q0, input logic qm1);
        case ({q0, qm1})
            2'b01:   return BOOTH_ADD;
            2'b10:   return BOOTH_SUB;
            default: return BOOTH_NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_seq_multiplier_step.sv
// ---------------------------------------------------------------------------
// booth_seq_multiplier_step (booth_step)
// One combinational radix-2 Booth iteration: conditional add/subtract of M
// into A, then arithmetic right shift of {A, Q, Q(-1)} by one bit.
// Ports:
//   i_a   [WIDTH:0]   partial remainder A (one guard bit)
//   i_q   [WIDTH-1:0] multiplier/low product register Q
//   i_qm1             Q(-1) bit
//   i_m   [WIDTH:0]   sign-extended multiplicand M
//   o_a, o_q, o_qm1   next {A, Q, Q(-1)}
// ---------------------------------------------------------------------------
module booth_step
    import booth_seq_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   i_a,
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_qm1,
    input  logic [WIDTH:0]   i_m,
    output logic [WIDTH:0]   o_a,
    output logic [WIDTH-1:0] o_q,
    output logic             o_qm1
);

    booth_op_t          w_op;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH+1:0] w_full;
    logic [2*WIDTH+1:0] w_shifted;

    always_comb begin
        w_op = booth_decode(i_q[0], i_qm1);
        case (w_op)
            BOOTH_ADD: w_sum = i_a + i_m;
            // Subtract as A + ~M + 1, modulo 2^(WIDTH+1).
            BOOTH_SUB: w_sum = i_a + ~i_m + {{WIDTH{1'b0}}, 1'b1};
            default:   w_sum = i_a;
        endcase
        w_full    = {w_sum, i_q, i_qm1};
        // Arithmetic shift: replicate the sign bit of the updated A.
        w_shifted = {w_sum[WIDTH], w_full[2*WIDTH+1:1]};
        o_a       = w_shifted[2*WIDTH+1:WIDTH+1];
        o_q       = w_shifted[WIDTH:1];
        o_qm1     = w_shifted[0];
    end

endmodule

// File: rtl/booth_seq_multiplier.sv
// ---------------------------------------------------------------------------
// booth_seq_multiplier
// Sequential radix-2 Booth multiplier, one Booth step per clock.
// Handshake: start is accepted in IDLE or DONE (back-to-back). busy is high
// for exactly WIDTH cycles, then done pulses for one cycle with the product.
// start while busy is ignored; operands are only captured on acceptance.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start                 request, sampled on rising clk edge
//   multiplicand [W-1:0]  signed M
//   multiplier   [W-1:0]  signed Q
//   busy                  high in RUN
//   done                  one-cycle completion pulse
//   product    [2W-1:0]   signed result, held until next completion
//   dbg_state  [1:0]      current FSM state (observability)
// ---------------------------------------------------------------------------
module booth_seq_multiplier
    import booth_seq_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [1:0]         dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH:0]     r_a;
    logic [WIDTH-1:0]   r_q;
    logic               r_qm1;
    logic [WIDTH:0]     r_m;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_product;

    logic [WIDTH:0]     w_a_nxt;
    logic [WIDTH-1:0]   w_q_nxt;
    logic               w_qm1_nxt;
    logic               w_accept;
    logic               w_last;

    assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    // The step taken while count is 1 brings it to 0: that is the final one.
    assign w_last   = (r_state == ST_RUN) && (r_count == CW'(1));

    booth_step #(.WIDTH(WIDTH)) u_step (
        .i_a   (r_a),
        .i_q   (r_q),
        .i_qm1 (r_qm1),
        .i_m   (r_m),
        .o_a   (w_a_nxt),
        .o_q   (w_q_nxt),
        .o_qm1 (w_qm1_nxt)
    );

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // FSM: next-state logic
    always_comb begin
        w_state_nxt = ST_IDLE;
        case (r_state)
            ST_IDLE: w_state_nxt = w_accept ? ST_RUN  : ST_IDLE;
            ST_RUN:  w_state_nxt = w_last   ? ST_DONE : ST_RUN;
            ST_DONE: w_state_nxt = w_accept ? ST_RUN  : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        dbg_state = r_state;
        case (r_state)
            ST_RUN:  busy = 1'b1;
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign product = r_product;

    // Datapath: operand capture, Booth iterations, product register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a       <= '0;
            r_q       <= '0;
            r_qm1     <= 1'b0;
            r_m       <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_a     <= '0;
            r_q     <= multiplier;
            r_qm1   <= 1'b0;
            r_m     <= {multiplicand[WIDTH-1], multiplicand};
            r_count <= CW'(WIDTH);
        end else if (r_state == ST_RUN) begin
            r_a     <= w_a_nxt;
            r_q     <= w_q_nxt;
            r_qm1   <= w_qm1_nxt;
            r_count <= r_count - CW'(1);
            if (w_last) r_product <= {w_a_nxt[WIDTH-1:0], w_q_nxt};
        end
    end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
module tb_booth_seq_multiplier;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   mcand = '0;
    logic [W-1:0]   mplier = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;
    logic [1:0]     dbg_state;

    always #5 clk = ~clk;

    booth_seq_multiplier #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (mcand),
        .multiplier   (mplier),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .dbg_state    (dbg_state)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sb;
        sa = {{W{a[W-1]}}, a};
        sb = {{W{b[W-1]}}, b};
        return sa * sb;
    endfunction

    // Model tracks edges elapsed since the accepting edge: busy for W cycles,
    // done in the next one, product updated on the W-th edge.
    logic           m_active;
    int             m_k;
    logic [2*W-1:0] m_pend;
    logic [2*W-1:0] exp_product;
    logic           exp_busy;
    logic           exp_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active    <= 1'b0;
            m_k         <= 0;
            m_pend      <= '0;
            exp_product <= '0;
        end else if (start && (!m_active || m_k == W)) begin
            m_active <= 1'b1;
            m_k      <= 0;
            m_pend   <= ref_mul(mcand, mplier);
        end else if (m_active) begin
            if (m_k == W) m_active <= 1'b0;
            else begin
                m_k <= m_k + 1;
                if (m_k + 1 == W) exp_product <= m_pend;
            end
        end
    end

    assign exp_busy = m_active && (m_k < W);
    assign exp_done = m_active && (m_k == W);

    // ---------------- scoreboard compare, every cycle ----------------
    always @(negedge clk) begin
        if (!rst) begin
            check("busy", 32'(busy), 32'(exp_busy));
            check("done", 32'(done), 32'(exp_done));
            check("product", 32'(product), 32'(exp_product));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 40);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp, input string name);
        int lat;
        @(negedge clk);
        mcand  = a;
        mplier = b;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, "_busy_after_accept"}, 32'(busy), 32'd1);
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'(W + 1));
        check(name, 32'(product), 32'(exp));
    endtask

    // ---------------- directed stimulus ----------------
    logic [W-1:0]   b2b_a [4] = '{8'h02, 8'hFB, 8'h7F, 8'h80};
    logic [W-1:0]   b2b_b [4] = '{8'h03, 8'h04, 8'h7F, 8'h7F};
    logic [2*W-1:0] b2b_p [4] = '{16'h0006, 16'hFFEC, 16'h3F01, 16'hC080};

    initial begin
        int lat;
        int extra_done;

        // reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_product", 32'(product), 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);
        #2 rst = 1'b0;

        // pin the model with literals
        check("model_m128sq", 32'(ref_mul(8'h80, 8'h80)), 32'h4000);
        check("model_neg7x3", 32'(ref_mul(8'hF9, 8'h03)), 32'hFFEB);

        run_op(8'd3,  8'd5,  16'h000F, "p3x5");
        run_op(8'hF9, 8'h03, 16'hFFEB, "pm7x3");
        run_op(8'h03, 8'hF9, 16'hFFEB, "p3xm7");
        run_op(8'hFF, 8'hFF, 16'h0001, "pm1xm1");
        run_op(8'h80, 8'h80, 16'h4000, "pm128sq");
        run_op(8'h7F, 8'h80, 16'hC080, "p127xm128");

        // start re-asserted with new operands during RUN is ignored
        @(negedge clk);
        mcand  = 8'd10;
        mplier = 8'hFD;
        start  = 1'b1;
        @(negedge clk);
        mcand  = 8'd100;
        mplier = 8'd100;
        lat = 1;
        repeat (3) begin
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("ignore_latency", 32'(lat), 32'(W + 1));
        check("ignore_product", 32'(product), 32'hFFE2);
        extra_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) extra_done++;
        end
        check("ignore_single_done", 32'(extra_done), 32'd0);

        run_op(8'h00, 8'h80, 16'h0000, "p0xm128");
        run_op(8'd5,  8'd9,  16'h002D, "p5x9");

        // asynchronous reset mid-RUN
        @(negedge clk);
        mcand  = 8'd50;
        mplier = 8'd2;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_product", 32'(product), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        extra_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) extra_done++;
        end
        check("arst_no_done", 32'(extra_done), 32'd0);
        run_op(8'd6, 8'd7, 16'h002A, "p6x7");

        // back-to-back with start held high
        @(negedge clk);
        mcand  = b2b_a[0];
        mplier = b2b_b[0];
        start  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_done(lat);
            check("b2b_interval", 32'(lat), 32'(W + 1));
            check("b2b_product", 32'(product), 32'(b2b_p[i]));
            if (i == 3) start = 1'b0;
            else begin
                mcand  = b2b_a[i+1];
                mplier = b2b_b[i+1];
            end
        end
        repeat (4) @(negedge clk);
        check("b2b_final_hold", 32'(product), 32'hC080);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
